fifo_wr_arbiter: RTL

- Shares the single write port of the asynchronous FIFO between NUM_REQ requesters in the write-clock domain.
- Round-robin arbitration with packet locking: a granted requester keeps the port until its last beat or a burst cap.
- Drives wr_en/wr_data into the FIFO write side and honours its registered wr_full.
- Sits directly upstream of the FIFO; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE picks a winner, GRANT streams that winner's beats.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of the per-grant beat counter; it only has to reach MAX_BURST-1.
  function automatic int bcnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: the first asserted request at or after rr_ptr
// (wrapping modulo NUM_REQ) wins. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           req,
  input  logic [grant_w(NUM_REQ)-1:0]  rr_ptr,
  output logic [grant_w(NUM_REQ)-1:0]  winner,
  output logic                         any_req
);

  localparam int GW = grant_w(NUM_REQ);
  // One spare bit so NUM_REQ itself fits as the "nothing found" sentinel.
  localparam int OW = GW + 1;

  // Distance of each requester from the pointer, counted forwards with wrap.
  logic [OW-1:0] off [NUM_REQ];
  logic [OW-1:0] best_off;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
    assign off[gi] = (OW'(gi) >= {1'b0, rr_ptr})
                   ? OW'(gi) - {1'b0, rr_ptr}
                   : OW'(gi) + OW'(NUM_REQ) - {1'b0, rr_ptr};
  end

  // Keep the valid requester with the smallest forward distance.
  always_comb begin
    best_off = OW'(NUM_REQ);
    winner   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (off[i] < best_off)) begin
        best_off = off[i];
        winner   = GW'(i);
      end
    end
  end

  assign any_req = |req;

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between NUM_REQ requesters. Round-robin between
// grants, packet-locked within a grant, with a forced release after MAX_BURST
// beats so a long packet cannot starve the others.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [grant_w(NUM_REQ)-1:0]   grant_id,
  output logic                          busy
);

  localparam int GRANT_W = grant_w(NUM_REQ);
  localparam int BCNT_W  = bcnt_w(MAX_BURST);
  localparam logic [BCNT_W-1:0]  BCNT_LAST = BCNT_W'(MAX_BURST - 1);
  localparam logic [GRANT_W-1:0] GID_MAX   = GRANT_W'(NUM_REQ - 1);

  arb_state_t         state_reg,     state_next;
  logic [GRANT_W-1:0] rr_ptr_reg,    rr_ptr_next;
  logic [GRANT_W-1:0] grant_id_reg,  grant_id_next;
  logic [BCNT_W-1:0]  burst_cnt_reg, burst_cnt_next;

  logic [GRANT_W-1:0] pick_winner;
  logic               pick_any;
  logic               granted;
  logic               beat;
  logic               release_beat;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_reg),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  // Unpack the requester data lanes and steer ready to the grantee only.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi] = granted & ~wr_full & (grant_id_reg == GRANT_W'(gi));
  end

  assign granted = (state_reg == GRANT);

  // A beat moves only when the grantee has data and the FIFO has room; full
  // freezes everything, including the burst counter.
  assign beat         = granted & req_valid[grant_id_reg] & ~wr_full;
  assign release_beat = beat & (req_last[grant_id_reg] | (burst_cnt_reg == BCNT_LAST));

  assign wr_en    = beat;
  assign wr_data  = data_arr[grant_id_reg];
  assign grant_id = grant_id_reg;
  assign busy     = granted;

  // State, pointer, grantee and beat counter registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_id_reg  <= grant_id_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_id_next  = grant_id_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_id_next  = pick_winner;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (release_beat) begin
          // Priority moves past the releasing requester so it goes last next time.
          state_next     = IDLE;
          rr_ptr_next    = (grant_id_reg == GID_MAX) ? '0 : grant_id_reg + GRANT_W'(1);
          burst_cnt_next = '0;
        end else if (beat) begin
          burst_cnt_next = burst_cnt_reg + BCNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : fifo_wr_arbiter
